// File: rtl/store_buffer.sv
// Dual-lane store buffer: circular FIFO of pending stores drained one per cycle to memory.
// Optional store-to-load forwarding is enabled by defining STORE_BUFFER_FWD_EN.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       StoreEnM1,
  input  logic                       StoreEnM2,
  input  logic [31:0]                AddrM1,
  input  logic [31:0]                AddrM2,
  input  logic [31:0]                WriteDataM1,
  input  logic [31:0]                WriteDataM2,
  input  logic [2:0]                 AddressingControlM1,
  input  logic [2:0]                 AddressingControlM2,
  input  logic                       LoadEnM1,
  input  logic                       LoadEnM2,
  output logic                       StallM,
  output logic                       LoadHitM1,
  output logic                       LoadHitM2,
  output logic                       MemWE,
  output logic [31:0]                MemA,
  output logic [31:0]                MemWD,
  output logic [2:0]                 MemAC,
  input  logic                       MemReady,
  output logic                       Empty,
  output logic [$clog2(DEPTH):0]     Count
`ifdef STORE_BUFFER_FWD_EN
  ,
  output logic                       FwdValidM1,
  output logic                       FwdValidM2,
  output logic [31:0]                FwdDataM1,
  output logic [31:0]                FwdDataM2
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d, tail1, idx;
  logic [CW-1:0] count_q, count_d, needed, free;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [31:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [2:0]  ac_q   [DEPTH];
  logic accept, retire, hit1, hit2;

  always_comb begin
    needed  = CW'(StoreEnM1) + CW'(StoreEnM2);
    free    = CW'(DEPTH) - count_q;
    accept  = (needed <= free);
    retire  = (count_q != '0) && MemReady;
    tail1   = tail_q + PW'(StoreEnM1);
    head_d  = head_q + PW'(retire);
    tail_d  = accept ? tail_q + PW'(needed) : tail_q;
    count_d = count_q + (accept ? needed : '0) - CW'(retire);
    valid_d = valid_q;
    if (retire) valid_d[head_q] = 1'b0;
    if (accept && StoreEnM1) valid_d[tail_q] = 1'b1;
    if (accept && StoreEnM2) valid_d[tail1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      if (accept && StoreEnM1) begin
        addr_q[tail_q] <= AddrM1;
        data_q[tail_q] <= WriteDataM1;
        ac_q[tail_q]   <= AddressingControlM1;
      end
      if (accept && StoreEnM2) begin
        addr_q[tail1] <= AddrM2;
        data_q[tail1] <= WriteDataM2;
        ac_q[tail1]   <= AddressingControlM2;
      end
    end
  end

  // Outputs are forced idle while reset is asserted, even before the first reset edge.
  assign MemWE  = rst_n && (count_q != '0);
  assign MemA   = MemWE ? addr_q[head_q] : '0;
  assign MemWD  = MemWE ? data_q[head_q] : '0;
  assign MemAC  = MemWE ? ac_q[head_q]   : '0;
  assign Count  = rst_n ? count_q : '0;
  assign Empty  = (Count == '0);
  assign StallM = rst_n && !accept;

`ifdef STORE_BUFFER_FWD_EN
  logic [2:0]  yac1, yac2;
  logic [31:0] ydat1, ydat2;
  logic        fwd1, fwd2;
`endif

  // Walk entries oldest to youngest so the last match is the youngest store.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    idx  = '0;
`ifdef STORE_BUFFER_FWD_EN
    yac1 = '0; yac2 = '0; ydat1 = '0; ydat2 = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && addr_q[idx][31:2] == AddrM1[31:2]) begin
        hit1 = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        yac1 = ac_q[idx]; ydat1 = data_q[idx];
`endif
      end
      if (valid_q[idx] && addr_q[idx][31:2] == AddrM2[31:2]) begin
        hit2 = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        yac2 = ac_q[idx]; ydat2 = data_q[idx];
`endif
      end
    end
    if (StoreEnM1 && AddrM1[31:2] == AddrM2[31:2]) begin
      hit2 = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
      yac2 = AddressingControlM1; ydat2 = WriteDataM1;
`endif
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  assign fwd1       = LoadEnM1 && hit1 && AddressingControlM1 == 3'b010 && yac1 == 3'b010;
  assign fwd2       = LoadEnM2 && hit2 && AddressingControlM2 == 3'b010 && yac2 == 3'b010;
  assign FwdValidM1 = rst_n && fwd1;
  assign FwdValidM2 = rst_n && fwd2;
  assign FwdDataM1  = FwdValidM1 ? ydat1 : '0;
  assign FwdDataM2  = FwdValidM2 ? ydat2 : '0;
  assign LoadHitM1  = rst_n && LoadEnM1 && hit1 && !fwd1;
  assign LoadHitM2  = rst_n && LoadEnM2 && hit2 && !fwd2;
`else
  assign LoadHitM1  = rst_n && LoadEnM1 && hit1;
  assign LoadHitM2  = rst_n && LoadEnM2 && hit2;
`endif
endmodule
